// File: rtl/mem_stage_lsu_pkg.sv
// Shared encodings and helpers for the load/store memory stage.
package mem_stage_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_e;

  // Natural-alignment check; a double access on a 32-bit datapath is never legal.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [2:0] addr_lo,
                                         input logic       is64);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr_lo[0];
      SZ_W:    bad = (addr_lo[1:0] != 2'b00);
      default: bad = !is64 || (addr_lo != 3'b000);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering: store replication, byte enables, load extract/extend.
module lsu_align
  import mem_stage_lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int BE_W  = XLEN / 8,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [1:0]       st_size_i,
  input  logic [OFF_W-1:0] st_off_i,
  input  logic [XLEN-1:0]  st_data_i,
  output logic [BE_W-1:0]  st_be_o,
  output logic [XLEN-1:0]  st_wdata_o,
  input  logic [1:0]       ld_size_i,
  input  logic [OFF_W-1:0] ld_off_i,
  input  logic             ld_unsigned_i,
  input  logic [XLEN-1:0]  ld_rdata_i,
  output logic [XLEN-1:0]  ld_data_o
);

  logic [7:0]      mask8;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] low_mask;
  logic            sign_bit;

  // Enable mask of the access width, moved up to the addressed byte.
  always_comb begin
    case (st_size_i)
      SZ_B:    mask8 = 8'h01;
      SZ_H:    mask8 = 8'h03;
      SZ_W:    mask8 = 8'h0F;
      default: mask8 = 8'hFF;
    endcase
    st_be_o = mask8[BE_W-1:0] << st_off_i;
  end

  // Each byte lane takes the store byte that lands on it for the given size.
  for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
    logic [7:0] lane_b;
    // Pick the source byte for this lane.
    always_comb begin
      case (st_size_i)
        SZ_B:    lane_b = st_data_i[7:0];
        SZ_H:    lane_b = st_data_i[(gi % 2) * 8 +: 8];
        SZ_W:    lane_b = st_data_i[(gi % 4) * 8 +: 8];
        default: lane_b = st_data_i[gi * 8 +: 8];
      endcase
    end
    assign st_wdata_o[gi * 8 +: 8] = lane_b;
  end

  // Right-align the addressed bytes, then sign- or zero-fill above the access width.
  always_comb begin
    shifted = ld_rdata_i >> {ld_off_i, 3'b000};
    case (ld_size_i)
      SZ_B: begin
        low_mask = XLEN'(8'hFF);
        sign_bit = shifted[7];
      end
      SZ_H: begin
        low_mask = XLEN'(16'hFFFF);
        sign_bit = shifted[15];
      end
      SZ_W: begin
        low_mask = XLEN'(32'hFFFF_FFFF);
        sign_bit = shifted[31];
      end
      default: begin
        low_mask = '1;
        sign_bit = shifted[XLEN-1];
      end
    endcase
    ld_data_o = (shifted & low_mask) | ((sign_bit && !ld_unsigned_i) ? ~low_mask : '0);
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Pipeline memory stage: accepts EX/MEM ops, runs req/gnt/rvalid accesses, drives MEM/WB.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5,
  localparam int BE_W     = XLEN / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid_i,
  input  logic                 rf_we_i,
  input  logic                 mem_we_i,
  input  logic                 mem2rf_i,
  input  logic [1:0]           mem_size_i,
  input  logic                 mem_unsigned_i,
  input  logic [RF_ADDR_W-1:0] rf_waddr_i,
  input  logic [XLEN-1:0]      alu_result_i,
  input  logic [XLEN-1:0]      mem_wdata_i,
  output logic                 stall_o,
  output logic                 out_valid_o,
  output logic                 rf_we_o,
  output logic [RF_ADDR_W-1:0] rf_waddr_o,
  output logic                 mem2rf_o,
  output logic [XLEN-1:0]      mem_rdata_o,
  output logic [XLEN-1:0]      alu_result_o,
  output logic                 misalign_o,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  output logic [XLEN-1:0]      dmem_addr_o,
  output logic [BE_W-1:0]      dmem_be_o,
  output logic [XLEN-1:0]      dmem_wdata_o,
  input  logic                 dmem_gnt_i,
  input  logic                 dmem_rvalid_i,
  input  logic [XLEN-1:0]      dmem_rdata_i
);

  localparam int OFF_W = $clog2(BE_W);

  lsu_state_e state_q;

  // Copy of the accepted instruction, used after upstream has moved on.
  logic                 cap_rf_we_q, cap_mem2rf_q, cap_mem_we_q, cap_unsigned_q;
  logic [1:0]           cap_size_q;
  logic [RF_ADDR_W-1:0] cap_waddr_q;
  logic [XLEN-1:0]      cap_alu_q;

  // Bus-side registers, stable for the whole request phase.
  logic                 req_q, dmem_we_q;
  logic [XLEN-1:0]      dmem_addr_q, dmem_wdata_q;
  logic [BE_W-1:0]      dmem_be_q;

  // MEM/WB pipeline register.
  logic                 out_valid_q, rf_we_q, mem2rf_q, misalign_q;
  logic [RF_ADDR_W-1:0] rf_waddr_q;
  logic [XLEN-1:0]      mem_rdata_q, alu_result_q;

  logic [BE_W-1:0]      st_be;
  logic [XLEN-1:0]      st_wdata, ld_data;
  logic                 mem_op, bad_align;

  assign mem_op    = mem_we_i || mem2rf_i;
  assign bad_align = is_misaligned(mem_size_i, alu_result_i[2:0], 1'(XLEN == 64));

  lsu_align #(.XLEN(XLEN), .BE_W(BE_W), .OFF_W(OFF_W)) u_align (
    .st_size_i    (mem_size_i),
    .st_off_i     (alu_result_i[OFF_W-1:0]),
    .st_data_i    (mem_wdata_i),
    .st_be_o      (st_be),
    .st_wdata_o   (st_wdata),
    .ld_size_i    (cap_size_q),
    .ld_off_i     (cap_alu_q[OFF_W-1:0]),
    .ld_unsigned_i(cap_unsigned_q),
    .ld_rdata_i   (dmem_rdata_i),
    .ld_data_o    (ld_data)
  );

  // Stage FSM: accept in IDLE, hold request until grant, retire on response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cap_rf_we_q    <= 1'b0;
      cap_mem2rf_q   <= 1'b0;
      cap_mem_we_q   <= 1'b0;
      cap_unsigned_q <= 1'b0;
      cap_size_q     <= SZ_B;
      cap_waddr_q    <= '0;
      cap_alu_q      <= '0;
      req_q          <= 1'b0;
      dmem_we_q      <= 1'b0;
      dmem_addr_q    <= '0;
      dmem_wdata_q   <= '0;
      dmem_be_q      <= '0;
      out_valid_q    <= 1'b0;
      rf_we_q        <= 1'b0;
      mem2rf_q       <= 1'b0;
      misalign_q     <= 1'b0;
      rf_waddr_q     <= '0;
      mem_rdata_q    <= '0;
      alu_result_q   <= '0;
    end else begin
      out_valid_q <= 1'b0;
      misalign_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            cap_rf_we_q    <= rf_we_i;
            cap_mem2rf_q   <= mem2rf_i;
            cap_mem_we_q   <= mem_we_i;
            cap_unsigned_q <= mem_unsigned_i;
            cap_size_q     <= mem_size_i;
            cap_waddr_q    <= rf_waddr_i;
            cap_alu_q      <= alu_result_i;
            if (!mem_op || bad_align) begin
              // Completes without touching memory.
              out_valid_q  <= 1'b1;
              misalign_q   <= mem_op;
              rf_we_q      <= rf_we_i && !mem_op;
              mem2rf_q     <= mem2rf_i;
              rf_waddr_q   <= rf_waddr_i;
              mem_rdata_q  <= '0;
              alu_result_q <= alu_result_i;
            end else begin
              req_q        <= 1'b1;
              dmem_we_q    <= mem_we_i;
              dmem_addr_q  <= {alu_result_i[XLEN-1:OFF_W], OFF_W'(0)};
              dmem_be_q    <= st_be;
              dmem_wdata_q <= st_wdata;
              state_q      <= REQ;
            end
          end
        end
        REQ: begin
          if (dmem_gnt_i) begin
            req_q   <= 1'b0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (dmem_rvalid_i) begin
            out_valid_q  <= 1'b1;
            rf_we_q      <= cap_rf_we_q;
            mem2rf_q     <= cap_mem2rf_q;
            rf_waddr_q   <= cap_waddr_q;
            mem_rdata_q  <= cap_mem_we_q ? '0 : ld_data;
            alu_result_q <= cap_alu_q;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall_o      = (state_q != IDLE);
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = dmem_we_q;
  assign dmem_addr_o  = dmem_addr_q;
  assign dmem_be_o    = dmem_be_q;
  assign dmem_wdata_o = dmem_wdata_q;
  assign out_valid_o  = out_valid_q;
  assign rf_we_o      = rf_we_q;
  assign rf_waddr_o   = rf_waddr_q;
  assign mem2rf_o     = mem2rf_q;
  assign misalign_o   = misalign_q;
  assign mem_rdata_o  = mem_rdata_q;
  assign alu_result_o = alu_result_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for the memory stage (XLEN=32).
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i, rf_we_i, mem_we_i, mem2rf_i, mem_unsigned_i;
  logic [1:0]  mem_size_i;
  logic [4:0]  rf_waddr_i;
  logic [31:0] alu_result_i, mem_wdata_i;
  logic        stall_o, out_valid_o, rf_we_o, mem2rf_o, misalign_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] mem_rdata_o, alu_result_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.XLEN(32), .RF_ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .rf_we_i(rf_we_i), .mem_we_i(mem_we_i), .mem2rf_i(mem2rf_i),
    .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i), .rf_waddr_i(rf_waddr_i),
    .alu_result_i(alu_result_i), .mem_wdata_i(mem_wdata_i),
    .stall_o(stall_o), .out_valid_o(out_valid_o), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
    .mem2rf_o(mem2rf_o), .mem_rdata_o(mem_rdata_o), .alu_result_o(alu_result_o),
    .misalign_o(misalign_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
  );

  // Drive one EX/MEM instruction onto the inputs (stimulus only).
  task automatic drive(input logic v, input logic we_rf, input logic st, input logic ld,
                       input logic [1:0] sz, input logic uns, input logic [4:0] wa,
                       input logic [31:0] addr, input logic [31:0] wd);
    in_valid_i = v; rf_we_i = we_rf; mem_we_i = st; mem2rf_i = ld;
    mem_size_i = sz; mem_unsigned_i = uns; rf_waddr_i = wa;
    alu_result_i = addr; mem_wdata_i = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 2'd0, 0, 5'd0, 32'h0, 32'h0);
    dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 32'h0;
    tick(); tick();
    tests++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid_o); end
    tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", stall_o); end
    tests++; if (dmem_req_o !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", dmem_req_o); end
    tests++; if (dmem_be_o !== 4'h0 || alu_result_o !== 32'h0) begin fails++; $display("FAIL reset_regs: be %h alu %h want 0 0", dmem_be_o, alu_result_o); end
    rst = 1'b0;
    tick();
    $display("[TB] reset done");
  endtask

  task automatic test_alu();
    drive(1, 1, 0, 0, 2'd2, 0, 5'd5, 32'h1234, 32'h0);
    tick();
    drive(0, 0, 0, 0, 2'd0, 0, 5'd0, 32'h0, 32'h0);
    tests++; if (out_valid_o !== 1'b1) begin fails++; $display("FAIL alu_valid: got %b want 1", out_valid_o); end
    tests++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd5) begin fails++; $display("FAIL alu_rf: we %b waddr %0d want 1 5", rf_we_o, rf_waddr_o); end
    tests++; if (alu_result_o !== 32'h1234) begin fails++; $display("FAIL alu_result: got %h want 00001234", alu_result_o); end
    tests++; if (dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin fails++; $display("FAIL alu_no_req: req %b stall %b want 0 0", dmem_req_o, stall_o); end
    tick();
    tests++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL alu_pulse: got %b want 0", out_valid_o); end
    $display("[TB] alu op waddr=5 done");
  endtask

  task automatic test_store();
    drive(1, 0, 1, 0, 2'd0, 0, 5'd0, 32'h103, 32'hAB);
    tick();
    drive(0, 0, 0, 0, 2'd0, 0, 5'd0, 32'h0, 32'h0);
    tests++; if (stall_o !== 1'b1 || dmem_req_o !== 1'b1 || dmem_we_o !== 1'b1) begin fails++; $display("FAIL sb_req: stall %b req %b we %b want 1 1 1", stall_o, dmem_req_o, dmem_we_o); end
    tests++; if (dmem_addr_o !== 32'h100) begin fails++; $display("FAIL sb_addr: got %h want 00000100", dmem_addr_o); end
    tests++; if (dmem_be_o !== 4'b1000) begin fails++; $display("FAIL sb_be: got %b want 1000", dmem_be_o); end
    tests++; if (dmem_wdata_o !== 32'hABABABAB) begin fails++; $display("FAIL sb_wdata: got %h want abababab", dmem_wdata_o); end
    tick();
    tests++; if (dmem_req_o !== 1'b1 || dmem_be_o !== 4'b1000) begin fails++; $display("FAIL sb_hold: req %b be %b want 1 1000", dmem_req_o, dmem_be_o); end
    dmem_gnt_i = 1;
    tick();
    dmem_gnt_i = 0;
    tests++; if (dmem_req_o !== 1'b0 || stall_o !== 1'b1) begin fails++; $display("FAIL sb_wait: req %b stall %b want 0 1", dmem_req_o, stall_o); end
    dmem_rvalid_i = 1;
    tick();
    dmem_rvalid_i = 0;
    tests++; if (out_valid_o !== 1'b1 || stall_o !== 1'b0) begin fails++; $display("FAIL sb_done: valid %b stall %b want 1 0", out_valid_o, stall_o); end
    tests++; if (mem_rdata_o !== 32'h0 || mem2rf_o !== 1'b0 || rf_we_o !== 1'b0) begin fails++; $display("FAIL sb_wb: rdata %h mem2rf %b we %b want 0 0 0", mem_rdata_o, mem2rf_o, rf_we_o); end
    tick();
    tests++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL sb_pulse: got %b want 0", out_valid_o); end
    $display("[TB] sb 0x103 done");
  endtask

  task automatic test_loads();
    logic [1:0]  sz [3]  = '{2'd0, 2'd0, 2'd1};
    logic        un [3]  = '{1'b0, 1'b1, 1'b0};
    logic [31:0] rd [3]  = '{32'h0080_0000, 32'h0080_0000, 32'h8001_0000};
    logic [31:0] ex [3]  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001};
    logic [3:0]  be [3]  = '{4'b0100, 4'b0100, 4'b1100};
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 1, sz[i], un[i], 5'd10, 32'h102, 32'h0);
      tick();
      drive(0, 0, 0, 0, 2'd0, 0, 5'd0, 32'h0, 32'h0);
      tests++; if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b0 || dmem_be_o !== be[i] || dmem_addr_o !== 32'h100) begin
        fails++; $display("FAIL ld%0d_req: req %b we %b be %b addr %h want 1 0 %b 00000100", i, dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, be[i]); end
      dmem_gnt_i = 1;
      tick();
      dmem_gnt_i = 0; dmem_rvalid_i = 1; dmem_rdata_i = rd[i];
      tick();
      dmem_rvalid_i = 0;
      tests++; if (out_valid_o !== 1'b1 || mem_rdata_o !== ex[i]) begin
        fails++; $display("FAIL ld%0d_data: valid %b rdata %h want 1 %h", i, out_valid_o, mem_rdata_o, ex[i]); end
      tests++; if (rf_we_o !== 1'b1 || mem2rf_o !== 1'b1 || rf_waddr_o !== 5'd10) begin
        fails++; $display("FAIL ld%0d_wb: we %b mem2rf %b waddr %0d want 1 1 10", i, rf_we_o, mem2rf_o, rf_waddr_o); end
      $display("[TB] load %0d size=%0d uns=%0d rdata=%h", i, sz[i], un[i], mem_rdata_o);
      tick();
    end
  endtask

  task automatic test_misalign();
    drive(1, 1, 0, 1, 2'd2, 0, 5'd6, 32'h102, 32'h0);
    tick();
    drive(0, 0, 0, 0, 2'd0, 0, 5'd0, 32'h0, 32'h0);
    tests++; if (out_valid_o !== 1'b1 || misalign_o !== 1'b1 || rf_we_o !== 1'b0) begin
      fails++; $display("FAIL lw_mis: valid %b mis %b we %b want 1 1 0", out_valid_o, misalign_o, rf_we_o); end
    tests++; if (dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin fails++; $display("FAIL lw_mis_req: req %b stall %b want 0 0", dmem_req_o, stall_o); end
    tick();
    tests++; if (misalign_o !== 1'b0 || out_valid_o !== 1'b0) begin fails++; $display("FAIL lw_mis_pulse: mis %b valid %b want 0 0", misalign_o, out_valid_o); end
    drive(1, 0, 1, 0, 2'd3, 0, 5'd0, 32'h100, 32'h0);
    tick();
    drive(0, 0, 0, 0, 2'd0, 0, 5'd0, 32'h0, 32'h0);
    tests++; if (misalign_o !== 1'b1 || dmem_req_o !== 1'b0) begin fails++; $display("FAIL sd_mis: mis %b req %b want 1 0", misalign_o, dmem_req_o); end
    tick();
    $display("[TB] misaligned lw/sd done");
  endtask

  task automatic test_back_to_back();
    drive(1, 1, 0, 1, 2'd2, 0, 5'd3, 32'h200, 32'h0);
    tick();
    drive(1, 1, 0, 0, 2'd0, 0, 5'd7, 32'h55, 32'h0);
    for (int c = 0; c < 3; c++) begin
      tests++; if (stall_o !== 1'b1 || out_valid_o !== 1'b0) begin
        fails++; $display("FAIL b2b_stall%0d: stall %b valid %b want 1 0", c, stall_o, out_valid_o); end
      tick();
    end
    dmem_gnt_i = 1;
    tick();
    dmem_gnt_i = 0; dmem_rvalid_i = 1; dmem_rdata_i = 32'hDEADBEEF;
    tick();
    dmem_rvalid_i = 0;
    tests++; if (out_valid_o !== 1'b1 || rf_waddr_o !== 5'd3 || mem_rdata_o !== 32'hDEADBEEF || stall_o !== 1'b0) begin
      fails++; $display("FAIL b2b_load: valid %b waddr %0d rdata %h stall %b want 1 3 deadbeef 0", out_valid_o, rf_waddr_o, mem_rdata_o, stall_o); end
    tick();
    drive(0, 0, 0, 0, 2'd0, 0, 5'd0, 32'h0, 32'h0);
    tests++; if (out_valid_o !== 1'b1 || rf_waddr_o !== 5'd7 || alu_result_o !== 32'h55 || mem2rf_o !== 1'b0) begin
      fails++; $display("FAIL b2b_alu: valid %b waddr %0d alu %h mem2rf %b want 1 7 00000055 0", out_valid_o, rf_waddr_o, alu_result_o, mem2rf_o); end
    tick();
    $display("[TB] back-to-back load+alu done");
  endtask

  task automatic test_reset_mid();
    drive(1, 1, 0, 1, 2'd2, 0, 5'd4, 32'h300, 32'h0);
    tick();
    drive(0, 0, 0, 0, 2'd0, 0, 5'd0, 32'h0, 32'h0);
    dmem_gnt_i = 1;
    tick();
    dmem_gnt_i = 0;
    rst = 1'b1;
    #1;
    tests++; if (dmem_req_o !== 1'b0 || stall_o !== 1'b0 || dmem_addr_o !== 32'h0) begin
      fails++; $display("FAIL rstmid_bus: req %b stall %b addr %h want 0 0 0", dmem_req_o, stall_o, dmem_addr_o); end
    tests++; if (out_valid_o !== 1'b0 || alu_result_o !== 32'h0 || rf_waddr_o !== 5'd0) begin
      fails++; $display("FAIL rstmid_out: valid %b alu %h waddr %0d want 0 0 0", out_valid_o, alu_result_o, rf_waddr_o); end
    tick();
    rst = 1'b0; dmem_rvalid_i = 1; dmem_rdata_i = 32'h1111_1111;
    tick();
    dmem_rvalid_i = 0;
    tests++; if (out_valid_o !== 1'b0) begin fails++; $display("FAIL rstmid_late: valid %b want 0", out_valid_o); end
    drive(1, 1, 0, 0, 2'd0, 0, 5'd9, 32'h77, 32'h0);
    tick();
    drive(0, 0, 0, 0, 2'd0, 0, 5'd0, 32'h0, 32'h0);
    tests++; if (out_valid_o !== 1'b1 || rf_waddr_o !== 5'd9 || alu_result_o !== 32'h77) begin
      fails++; $display("FAIL rstmid_next: valid %b waddr %0d alu %h want 1 9 00000077", out_valid_o, rf_waddr_o, alu_result_o); end
    tick();
    $display("[TB] reset mid-transaction done");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_loads();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Parametrised successor of the pipeline memory stage. Accepts one EX/MEM instruction per cycle and issues data-memory accesses over a req/gnt/rvalid handshake with byte enables. Supports sub-word loads and stores with sign/zero extension, detects misaligned accesses, and stalls the upstream pipeline while an access is outstanding. Results are registered as the MEM/WB pipeline register and feed the writeback stage.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
RF_ADDR_W, 5, register-file address width.
BE_W, XLEN/8, byte-enable width (derived, not overridden).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid_i  in  1  EX/MEM instruction valid
rf_we_i  in  1  register write enable
mem_we_i  in  1  store
mem2rf_i  in  1  load (writeback data comes from memory)
mem_size_i  in  2  access size: 0=byte, 1=half, 2=word, 3=double (XLEN=64 only)
mem_unsigned_i  in  1  zero-extend the load
rf_waddr_i  in  RF_ADDR_W  destination register
alu_result_i  in  XLEN  effective address / ALU result
mem_wdata_i  in  XLEN  store data (right-aligned)
stall_o  out  1  upstream must hold the EX/MEM register
out_valid_o  out  1  MEM/WB valid
rf_we_o  out  1  registered write enable
rf_waddr_o  out  RF_ADDR_W  registered destination register
mem2rf_o  out  1  registered load flag
mem_rdata_o  out  XLEN  extended load data
alu_result_o  out  XLEN  registered ALU result
misalign_o  out  1  one-cycle misaligned-access flag
dmem_req_o  out  1  memory request
dmem_we_o  out  1  request is a write
dmem_addr_o  out  XLEN  word-aligned address
dmem_be_o  out  BE_W  byte enables
dmem_wdata_o  out  XLEN  lane-replicated store data
dmem_gnt_i  in  1  request accepted
dmem_rvalid_i  in  1  response valid (loads and stores)
dmem_rdata_i  in  XLEN  response data

Behaviour:
- Reset (async): state IDLE. All outputs 0, including dmem_req_o and stall_o.
- Transaction signals (dmem_*) are driven from registers captured at accept.
- FSM states:
  - IDLE: if in_valid_i, capture all inputs.
    - Non-memory op: the MEM/WB registers load directly; out_valid_o=1 next cycle (1-cycle latency).
    - Misaligned memory op: no request; out_valid_o=1 and misalign_o=1 next cycle, rf_we_o forced 0.
    - Aligned memory op: go to REQ; out_valid_o=0 next cycle.
  - REQ: dmem_req_o=1 with stable addr/be/wdata/we until dmem_gnt_i; on gnt go to WAIT.
  - WAIT: dmem_req_o=0; on dmem_rvalid_i load the MEM/WB registers, set out_valid_o=1 next cycle, return to IDLE.
- stall_o = (state != IDLE). In the accept cycle stall_o is 0, so the upstream register advances; the captured copy is used.
- dmem_rvalid_i arrives at least one cycle after gnt. An rvalid seen in IDLE or REQ is ignored.
- Misalignment: half requires addr[0]=0; word requires addr[1:0]=0; double requires addr[2:0]=0. Size 3 with XLEN=32 is treated as misaligned.
- Address and enables:
  - dmem_addr_o = addr with low log2(BE_W) bits cleared.
  - dmem_be_o = ({1,3,15,255} masked to BE_W) << byte offset.
  - dmem_wdata_o = store data replicated across lanes at the access size.
- Load data: shift dmem_rdata_i right by offset*8, then sign- or zero-extend from the access size. A store writes mem_rdata_o=0, and its rf_we_o passes through as given.
- out_valid_o is a single-cycle pulse per accepted instruction. While out_valid_o=0, the other outputs hold their last values.
- Reset mid-transaction: dmem_req_o drops immediately and the state returns to IDLE. A late rvalid after reset is ignored.

Decomposition:
- Shared package holds:
  - size encodings (SZ_B, SZ_H, SZ_W, SZ_D);
  - FSM state enum (IDLE, REQ, WAIT);
  - function computing the misalignment check.
- One combinational sub-module, lsu_align, contains store lane replication, byte-enable generation and load extract/extend. The top level holds the FSM, capture registers and MEM/WB registers.

Test Plan:
1. ALU op, rf_we=1, waddr=5, alu_result=0x1234 -> next cycle out_valid_o=1, rf_we_o=1, rf_waddr_o=5, alu_result_o=0x1234; no dmem_req_o; stall_o stays 0.
2. SB to 0x103 with data 0xAB, gnt after 2 cycles, rvalid 1 cycle later -> dmem_addr_o=0x100, dmem_be_o=4'b1000, dmem_wdata_o=0xABABABAB. stall_o is high from the cycle after accept until rvalid; one out_valid_o pulse follows.
3. LB from 0x102, rdata=0x0080_0000 -> mem_rdata_o=0xFFFFFF80. Repeat as LBU -> 0x00000080. LH from 0x102, rdata=0x8001_0000 -> 0xFFFF8001.
4. LW from 0x102 -> no dmem_req_o; next cycle out_valid_o=1, misalign_o=1, rf_we_o=0.
5. Back-to-back load then ALU op with gnt delayed 3 cycles -> the ALU op is held by stall_o and accepted in the IDLE cycle after the load's rvalid. out_valid_o pulses arrive in program order.
6. Assert rst while in WAIT, then rvalid arrives -> dmem_req_o=0 and outputs are 0 immediately. The late rvalid produces no out_valid_o, and the next instruction completes normally.
